// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: datapath width, opcodes and
// the FSM state encoding used by alu_execute_unit.
package alu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ITER_CNT_W = 5;        // log2(XLEN)
    localparam int unsigned ACC_W      = 2 * XLEN;

    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OP_AND  = 4'b0010;
    localparam logic [3:0] ALU_OP_OR   = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0101;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0110;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0111;
    localparam logic [3:0] ALU_OP_MULU = 4'b1000;
    localparam logic [3:0] ALU_OP_DIVU = 4'b1001;
    localparam logic [3:0] ALU_OP_REMU = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per step.
// Ports:
//   clk, reset      clock, async active-low reset
//   load            capture op_a/op_b/is_div, clear the iteration counter
//   step            advance one iteration
//   is_div          1 = restoring divide, 0 = shift-add multiply
//   op_a, op_b      multiplier/dividend and multiplicand/divisor
//   last_iter_c     counter is on its final iteration
//   quotient_c      post-step low word (quotient or product low)
//   remainder_c     post-step high word (remainder)
module alu_iter_muldiv
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            last_iter_c,
    output logic [XLEN-1:0] quotient_c,
    output logic [XLEN-1:0] remainder_c
);

    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [XLEN-1:0]       opb_q;
    logic [ITER_CNT_W-1:0] cnt_q;
    logic                  is_div_q;
    logic [XLEN:0]         mul_sum_c;
    logic [XLEN:0]         div_shift_c;
    logic [XLEN:0]         div_diff_c;

    // One iteration. Multiply: add multiplicand to the high half when the
    // current multiplier LSB is set, then shift the 65-bit {carry,acc} right.
    // Divide: shift the next dividend bit into the partial remainder and
    // keep the subtraction only when it does not borrow.
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift_c = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-1]};
        div_diff_c  = div_shift_c - {1'b0, opb_q};
        acc_d       = acc_q;
        if (is_div_q) begin
            if (!div_diff_c[XLEN]) begin
                acc_d = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {div_shift_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {mul_sum_c, acc_q[XLEN-1:1]};
        end
    end

    // Post-step values so the caller can capture the result on the last edge
    assign quotient_c  = acc_d[XLEN-1:0];
    assign remainder_c = acc_d[ACC_W-1:XLEN];
    assign last_iter_c = (cnt_q == ITER_CNT_W'(XLEN - 1));

    // Accumulator, operand and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else if (load) begin
            acc_q    <= {XLEN'(0), op_a};
            opb_q    <= op_b;
            cnt_q    <= '0;
            is_div_q <= is_div;
        end else if (step) begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_q + ITER_CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic/shift/compare plus
// 32-iteration unsigned MULU/DIVU/REMU behind a start/busy/done handshake.
// Ports:
//   clk, reset        clock, async active-low reset
//   start             request, honoured only while busy=0
//   alu_op            opcode, sampled with start
//   operand_a/b       operands, sampled with start
//   result, zero      registered result and result==0, updated on done
//   div_by_zero       set on done of DIVU/REMU with divisor 0, else cleared
//   busy              iterative op in flight
//   done              one-cycle pulse when result is valid
module alu_execute_unit
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            div_by_zero,
    output logic            busy,
    output logic            done
);

    alu_state_e      state_q;
    alu_state_e      state_d;
    logic            rem_sel_q;
    logic            rem_sel_d;
    logic [XLEN-1:0] result_d;
    logic            zero_d;
    logic            dbz_d;
    logic            busy_d;
    logic            done_d;
    logic            load_c;
    logic            step_c;
    logic            is_div_c;
    logic            last_iter_c;
    logic [XLEN-1:0] quotient_c;
    logic [XLEN-1:0] remainder_c;
    logic [XLEN-1:0] single_c;
    logic [ITER_CNT_W-1:0] shamt_c;

    assign shamt_c = operand_b[ITER_CNT_W-1:0];

    // Single-cycle operations; illegal opcodes yield zero
    always_comb begin
        single_c = '0;
        case (alu_op)
            ALU_OP_ADD: single_c = operand_a + operand_b;
            ALU_OP_SUB: single_c = operand_a - operand_b;
            ALU_OP_AND: single_c = operand_a & operand_b;
            ALU_OP_OR:  single_c = operand_a | operand_b;
            ALU_OP_XOR: single_c = operand_a ^ operand_b;
            ALU_OP_SLT: single_c = XLEN'($signed(operand_a) < $signed(operand_b));
            ALU_OP_SLL: single_c = operand_a << shamt_c;
            ALU_OP_SRL: single_c = operand_a >> shamt_c;
            default:    single_c = '0;
        endcase
    end

    alu_iter_muldiv u_iter (
        .clk         (clk),
        .reset       (reset),
        .load        (load_c),
        .step        (step_c),
        .is_div      (is_div_c),
        .op_a        (operand_a),
        .op_b        (operand_b),
        .last_iter_c (last_iter_c),
        .quotient_c  (quotient_c),
        .remainder_c (remainder_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        result_d  = result;
        dbz_d     = div_by_zero;
        busy_d    = busy;
        done_d    = 1'b0;
        load_c    = 1'b0;
        step_c    = 1'b0;
        is_div_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (alu_op)
                        ALU_OP_MULU: begin
                            load_c  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = ST_MUL;
                        end
                        ALU_OP_DIVU, ALU_OP_REMU: begin
                            if (operand_b == '0) begin
                                result_d = (alu_op == ALU_OP_DIVU) ? '1 : operand_a;
                                dbz_d    = 1'b1;
                                done_d   = 1'b1;
                            end else begin
                                load_c    = 1'b1;
                                is_div_c  = 1'b1;
                                rem_sel_d = (alu_op == ALU_OP_REMU);
                                busy_d    = 1'b1;
                                state_d   = ST_DIV;
                            end
                        end
                        default: begin
                            result_d = single_c;
                            dbz_d    = 1'b0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                step_c = 1'b1;
                if (last_iter_c) begin
                    if (state_q == ST_DIV && rem_sel_q) begin
                        result_d = remainder_c;
                    end else begin
                        result_d = quotient_c;
                    end
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // result only moves on a done edge, so this tracks it exactly
        zero_d = (result_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rem_sel_q   <= 1'b0;
            result      <= '0;
            zero        <= 1'b1;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_sel_q   <= rem_sel_d;
            result      <= result_d;
            zero        <= zero_d;
            div_by_zero <= dbz_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_execute_unit.sv
// Directed self-checking bench for alu_execute_unit.
module tb_alu_execute_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        zero;
    logic        div_by_zero;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int lat;
    int bcy;
    int dcnt;

    always #5 clk = ~clk;

    alu_execute_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_op      (alu_op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .result      (result),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int latency, output int busy_cycles);
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        alu_op    = 4'hF;
        operand_a = ~a;
        operand_b = ~b;
        latency     = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && latency < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            latency++;
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        alu_op    = 4'h0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(ALU_OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, lat, bcy);
        check("add_result", result, 32'h8000_0000);
        check("add_zero", 32'(zero), 32'd0);
        check("add_latency", 32'(lat), 32'd1);
        check("add_busy", 32'(bcy), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);

        run_op(ALU_OP_SUB, 32'd5, 32'd5, lat, bcy);
        check("sub_result", result, 32'h0);
        check("sub_zero", 32'(zero), 32'd1);

        run_op(ALU_OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, lat, bcy);
        check("slt_result", result, 32'd1);
        run_op(ALU_OP_SRL, 32'h8000_0000, 32'h0000_0024, lat, bcy);
        check("srl_result", result, 32'h0800_0000);
        run_op(ALU_OP_SLL, 32'h0000_0001, 32'h0000_001F, lat, bcy);
        check("sll_result", result, 32'h8000_0000);
        run_op(ALU_OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, bcy);
        check("xor_result", result, 32'hFF00_EDCB);
        run_op(4'hC, 32'd5, 32'd6, lat, bcy);
        check("illegal_result", result, 32'h0);
        check("illegal_zero", 32'(zero), 32'd1);
        check("illegal_latency", 32'(lat), 32'd1);

        run_op(ALU_OP_MULU, 32'd123, 32'd456, lat, bcy);
        check("mul_result", result, 32'h0000_DB18);
        check("mul_latency", 32'(lat), 32'd33);
        check("mul_busy_cycles", 32'(bcy), 32'd32);
        check("mul_busy_after", 32'(busy), 32'd0);
        check("mul_dbz", 32'(div_by_zero), 32'd0);

        run_op(ALU_OP_MULU, 32'h0001_0000, 32'h0001_0000, lat, bcy);
        check("mul_wrap_result", result, 32'h0);
        check("mul_wrap_zero", 32'(zero), 32'd1);

        run_op(ALU_OP_DIVU, 32'd100, 32'd7, lat, bcy);
        check("divu_result", result, 32'd14);
        check("divu_latency", 32'(lat), 32'd33);
        check("divu_dbz", 32'(div_by_zero), 32'd0);
        // issued in the done cycle of the previous op
        run_op(ALU_OP_REMU, 32'd100, 32'd7, lat, bcy);
        check("remu_result", result, 32'd2);
        check("remu_latency", 32'(lat), 32'd33);

        run_op(ALU_OP_DIVU, 32'h1234_5678, 32'h0, lat, bcy);
        check("divz_result", result, 32'hFFFF_FFFF);
        check("divz_dbz", 32'(div_by_zero), 32'd1);
        check("divz_latency", 32'(lat), 32'd1);
        run_op(ALU_OP_REMU, 32'd9, 32'h0, lat, bcy);
        check("remz_result", result, 32'd9);
        check("remz_dbz", 32'(div_by_zero), 32'd1);
        run_op(ALU_OP_ADD, 32'd1, 32'd1, lat, bcy);
        check("dbz_clear", 32'(div_by_zero), 32'd0);
        check("add2_result", result, 32'd2);

        // start while busy is ignored
        @(negedge clk);
        alu_op    = ALU_OP_MULU;
        operand_a = 32'd123;
        operand_b = 32'd456;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        repeat (8) begin
            @(negedge clk);
            lat++;
        end
        alu_op    = ALU_OP_ADD;
        operand_a = 32'd2;
        operand_b = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat++;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_no_done", 32'(done), 32'd0);
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ign_result", result, 32'h0000_DB18);
        check("ign_latency", 32'(lat), 32'd33);

        // reset mid-operation aborts without done
        @(negedge clk);
        alu_op    = ALU_OP_MULU;
        operand_a = 32'd5;
        operand_b = 32'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_zero", 32'(zero), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        dcnt  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("abort_no_done", 32'(dcnt), 32'd0);

        run_op(ALU_OP_ADD, 32'd2, 32'd3, lat, bcy);
        check("post_rst_add", result, 32'd5);
        check("post_rst_latency", 32'(lat), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
